// File: rtl/han_carlson_subtractor_pipe_if.sv
// Operand/result handshake bundle for the 4-bit Han-Carlson subtractor pipe.
// slave is the subtractor's view; master is the producer/consumer's view.
interface han_carlson_subtractor_pipe_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] input1;
  logic [3:0] input2;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] diff;
  logic       borrow;
  logic       overflow;
  logic       zero;

  modport slave (
    input  in_valid, input1, input2, out_ready,
    output in_ready, out_valid, diff, borrow, overflow, zero
  );

  modport master (
    output in_valid, input1, input2, out_ready,
    input  in_ready, out_valid, diff, borrow, overflow, zero
  );
endinterface

// File: rtl/han_carlson_subtractor_pipe.sv
// 4-bit subtractor (input1 - input2) on a Han-Carlson prefix network, 2-stage pipe, latency 2.
// Backpressure: valid/ready, each stage advances when downstream is empty or draining; holds 2 max.
module han_carlson_subtractor_pipe (
  input  logic                                clk,
  input  logic                                rst,
  han_carlson_subtractor_pipe_if.slave        bus
);

  logic       s1_en;
  logic       s2_en;
  logic       v1;
  logic       v2;

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] p;
  logic [3:0] g;
  logic       g0_ci;
  logic       grp32_g;
  logic       grp32_p;
  logic       grp10;
  logic       grp30;

  logic [3:0] p_q;
  logic       grp10_q;
  logic       grp30_q;
  logic       g2_q;
  logic       g0_q;
  logic       a3_q;

  logic       grp20;
  logic [3:0] diff_d;
  logic       overflow_d;

  logic [3:0] diff_q;
  logic       borrow_q;
  logic       overflow_q;
  logic       zero_q;

  assign s2_en        = ~v2 | bus.out_ready;
  assign s1_en        = ~v1 | s2_en;
  assign bus.in_ready = s1_en & ~rst;

  // Subtraction as input1 + ~input2 + 1, with the carry-in folded into bit 0.
  always_comb begin
    a       = bus.input1;
    b       = ~bus.input2;
    p       = a ^ b;
    g       = a & b;
    g0_ci   = g[0] | p[0];
    grp32_g = g[3] | (p[3] & g[2]);
    grp32_p = p[3] & p[2];
    grp10   = g[1] | (p[1] & g0_ci);
    grp30   = grp32_g | (grp32_p & grp10);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      p_q     <= 4'd0;
      grp10_q <= 1'b0;
      grp30_q <= 1'b0;
      g2_q    <= 1'b0;
      g0_q    <= 1'b0;
      a3_q    <= 1'b0;
    end else if (s1_en) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        p_q     <= p;
        grp10_q <= grp10;
        grp30_q <= grp30;
        g2_q    <= g[2];
        g0_q    <= g0_ci;
        a3_q    <= bus.input1[3];
      end
    end
  end

  // Final grey cell on bit 2 completes the carry vector {c3, c2, c1, c0=1}.
  always_comb begin
    grp20      = g2_q | (p_q[2] & grp10_q);
    diff_d     = p_q ^ {grp20, grp10_q, g0_q, 1'b1};
    overflow_d = ~p_q[3] & (diff_d[3] ^ a3_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2         <= 1'b0;
      diff_q     <= 4'd0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (s2_en) begin
      v2 <= v1;
      if (v1) begin
        diff_q     <= diff_d;
        borrow_q   <= ~grp30_q;
        overflow_q <= overflow_d;
        zero_q     <= (diff_d == 4'd0);
      end
    end
  end

  assign bus.out_valid = v2;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_han_carlson_subtractor_pipe.sv
// Bench for han_carlson_subtractor_pipe: directed corner cases plus a random-ready sweep of
// all 256 operand pairs, scored against an arithmetic reference model.
module tb_han_carlson_subtractor_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n_out;
  logic [6:0] exp_q[$];

  han_carlson_subtractor_pipe_if bus ();

  han_carlson_subtractor_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {diff, borrow, overflow, zero} from plain integer arithmetic.
  function automatic logic [6:0] model(input logic [3:0] x, input logic [3:0] y);
    int sx, sy, sd;
    logic [3:0] d;
    d  = x - y;
    sx = x[3] ? int'(x) - 16 : int'(x);
    sy = y[3] ? int'(y) - 16 : int'(y);
    sd = sx - sy;
    return {d, (x < y), (sd < -8 || sd > 7), (d == 4'd0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: transfers are decided at the coming rising edge, so look at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        checks++;
        assert (exp_q.size() != 0)
        else begin
          errors++;
          $error("FAIL sb_unexpected observed=%0h expected=none",
                 {bus.diff, bus.borrow, bus.overflow, bus.zero});
        end
        if (exp_q.size() != 0)
          check("sb_result", {bus.diff, bus.borrow, bus.overflow, bus.zero}, exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.input1, bus.input2));
    end
  end

  task automatic single(input logic [3:0] x, input logic [3:0] y, input string tag);
    logic [6:0] e;
    e = model(x, y);
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.input1    = x;
    bus.input2    = y;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, bus.out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_lat2_valid"}, bus.out_valid, 1'b1);
    check({tag, "_result"}, {bus.diff, bus.borrow, bus.overflow, bus.zero}, e);
  endtask

  initial begin
    logic [3:0] pa [3];
    logic [3:0] pb [3];
    logic [3:0] hold;
    int k, seen, idx, base, cyc;

    checks = 0;
    errors = 0;
    n_out  = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.input1    = 4'd0;
    bus.input2    = 4'd0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_outputs", {bus.diff, bus.borrow, bus.overflow, bus.zero}, 7'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // Directed arithmetic corners
    single(4'd9, 4'd3, "9m3");
    single(4'd3, 4'd9, "3m9");
    single(4'd8, 4'd1, "8m1");
    single(4'd5, 4'd5, "5m5");
    single(4'd0, 4'd15, "0m15");

    // Backpressure: three pairs offered, only two fit
    pa[0] = 4'd7;  pb[0] = 4'd2;
    pa[1] = 4'd1;  pb[1] = 4'd14;
    pa[2] = 4'd12; pb[2] = 4'd12;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bus.input1 = pa[k];
      bus.input2 = pb[k];
      @(negedge clk);
      if (bus.in_ready) k++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_accepted", k, 2);
    check("bp_in_ready", bus.in_ready, 1'b0);
    check("bp_out_valid", bus.out_valid, 1'b1);
    hold = bus.diff;
    @(negedge clk);
    check("bp_hold_diff", bus.diff, hold);
    check("bp_hold_diff_val", bus.diff, model(pa[0], pb[0]) >> 3);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && k < 3; c++) begin
      @(negedge clk);
      if (bus.in_ready) k++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("bp_third_accepted", k, 3);
    for (int c = 0; c < 10 && (exp_q.size() != 0 || bus.out_valid); c++) begin
      @(posedge clk); #1;
    end
    check("bp_drained", exp_q.size(), 0);

    // Reset with two transactions in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.input1    = 4'd2;
    bus.input2    = 4'd7;
    @(posedge clk); #1;
    bus.input1 = 4'd12;
    bus.input2 = 4'd4;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    check("mid_rst_full", bus.out_valid, 1'b1);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("mid_rst_no_ghosts", seen, 0);

    // All 256 pairs back-to-back with random downstream ready
    @(posedge clk); #1;
    base = n_out;
    idx  = 0;
    cyc  = 0;
    bus.in_valid = 1'b1;
    while (idx < 256 && cyc < 4000) begin
      bus.input1    = idx[7:4];
      bus.input2    = idx[3:0];
      bus.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (bus.in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("sweep_all_accepted", idx, 256);
    for (int c = 0; c < 20 && (exp_q.size() != 0 || bus.out_valid); c++) begin
      @(posedge clk); #1;
    end
    check("sweep_result_count", n_out - base, 256);
    check("sweep_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
